// File: rtl/instr_encoder.sv
// instr_encoder: assembles 32-bit MIPS instruction words from request fields.
// It writes them one per cycle into instruction memory at an auto-incrementing
// word address. It is used to preload a program while the CPU is held in reset.
// Build option: define ENC_CHECK_EN to make illegal kinds (8-15) trap into a
// sticky error state. Without it, illegal kinds are written as NOP words.
module instr_encoder #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        kind_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        shamt_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       target_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o
);

  // The pointer is one bit wider than the address, so "all words used" is a
  // distinct value and the pointer never wraps back onto address 0.
  localparam logic [ADDR_W:0] LAST_PTR = {1'b0, {ADDR_W{1'b1}}};

`ifdef ENC_CHECK_EN
  typedef enum logic [1:0] {LOAD, FULL, ERR} encState_t;
`else
  typedef enum logic [1:0] {LOAD, FULL} encState_t;
`endif

  encState_t         stateReg, stateNext;
  logic [ADDR_W:0]   ptrReg, ptrNext;
  logic [ADDR_W:0]   countReg, countNext;
  logic              memWeReg, memWeNext;
  logic [ADDR_W-1:0] memAddrReg, memAddrNext;
  logic [31:0]       memDataReg, memDataNext;
  logic [31:0]       encWord;
  logic              readyInt;
  logic              acceptFire;

  // Field assembly by instruction class; unused fields are ignored and
  // illegal classes produce an all-zero word (a NOP).
  always_comb begin
    encWord = 32'h0000_0000;
    case (kind_i)
      4'd0: encWord = {6'b000000, rs_i, rt_i, rd_i, shamt_i, funct_i};
      4'd1: encWord = {6'b001000, rs_i, rt_i, imm_i};
      4'd2: encWord = {6'b001010, rs_i, rt_i, imm_i};
      4'd3: encWord = {6'b000100, rs_i, rt_i, imm_i};
      4'd4: encWord = {6'b100011, rs_i, rt_i, imm_i};
      4'd5: encWord = {6'b101011, rs_i, rt_i, imm_i};
      4'd6: encWord = {6'b000010, target_i};
      4'd7: encWord = {6'b000011, target_i};
      default: encWord = 32'h0000_0000;
    endcase
  end

  // Ready depends only on state and reset; clear blocks the accept instead.
  assign readyInt   = !rst_i && (stateReg == LOAD);
  assign acceptFire = req_valid_i && readyInt && !clear_i;

  // Next-state logic: count follows the write strobe by one cycle, and the
  // pointer advances at accept time so back-to-back requests get new addresses.
  always_comb begin
    stateNext   = stateReg;
    ptrNext     = ptrReg;
    countNext   = countReg;
    memWeNext   = 1'b0;
    memAddrNext = memAddrReg;
    memDataNext = memDataReg;
    if (memWeReg) begin
      countNext = countReg + 1'b1;
    end
    if (clear_i) begin
      // A write already on the bus still completes, but the tally restarts.
      stateNext = LOAD;
      ptrNext   = '0;
      countNext = '0;
    end else if (acceptFire) begin
`ifdef ENC_CHECK_EN
      if (kind_i[3]) begin
        stateNext = ERR;
      end else
`endif
      begin
        memWeNext   = 1'b1;
        memAddrNext = ptrReg[ADDR_W-1:0];
        memDataNext = encWord;
        ptrNext     = ptrReg + 1'b1;
        if (ptrReg == LAST_PTR) begin
          stateNext = FULL;
        end
      end
    end
  end

  // State and output registers. Reset drops any pending write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateReg   <= LOAD;
      ptrReg     <= '0;
      countReg   <= '0;
      memWeReg   <= 1'b0;
      memAddrReg <= '0;
      memDataReg <= '0;
    end else begin
      stateReg   <= stateNext;
      ptrReg     <= ptrNext;
      countReg   <= countNext;
      memWeReg   <= memWeNext;
      memAddrReg <= memAddrNext;
      memDataReg <= memDataNext;
    end
  end

  assign req_ready_o = readyInt;
  assign mem_we_o    = memWeReg;
  assign mem_addr_o  = memAddrReg;
  assign mem_data_o  = memDataReg;
  assign count_o     = countReg;
  assign full_o      = (stateReg == FULL);
`ifdef ENC_CHECK_EN
  assign err_o       = (stateReg == ERR);
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a table of known encodings, hand
// sequences for full/clear/illegal/reset corners, and a random stream checked
// against an accept-count model of the loader.
module tb_instr_encoder;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef ENC_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              clear;
  logic              reqValid;
  logic              reqReady;
  logic [3:0]        kind;
  logic [4:0]        rs, rt, rd, shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memData;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  int checks = 0;
  int errors = 0;

  // Model state: words accepted / words written since reset or clear.
  int          mAccepted = 0;
  int          mWritten  = 0;
  bit          mErr      = 1'b0;
  bit          mPend     = 1'b0;
  int          mPendAddr = 0;
  logic [31:0] mPendData = '0;
  bit          mAfterRst = 1'b0;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] expData;
  } vec_t;
  vec_t tbl[10];

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .req_valid_i(reqValid), .req_ready_o(reqReady),
    .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt),
    .funct_i(funct), .imm_i(imm), .target_i(target),
    .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_data_o(memData),
    .count_o(count), .full_o(full), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Word value from the instruction-class rules, built arithmetically.
  function automatic logic [31:0] refEncode(input logic [3:0] k, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
    int unsigned opTab[8] = '{0, 8, 10, 4, 35, 43, 2, 3};
    int unsigned w;
    if (k == 0)
      w = (int'(s) << 21) + (int'(t) << 16) + (int'(d) << 11) + (int'(sh) << 6) + int'(fn);
    else if (k <= 5)
      w = (opTab[k] << 26) + (int'(s) << 21) + (int'(t) << 16) + int'(im);
    else if (k <= 7)
      w = (opTab[k] << 26) + int'(tg);
    else
      w = 0;
    return w;
  endfunction

  // One clock: check ready, advance the model with the applied inputs, then
  // compare all outputs one step after the edge.
  task automatic tick();
    bit expReady;
    #1;
    expReady = !rst && (mAccepted < DEPTH) && !mErr;
    chk("ready", {31'b0, reqReady}, {31'b0, expReady});
    @(posedge clk);
    if (rst) begin
      mAccepted = 0; mWritten = 0; mErr = 1'b0; mPend = 1'b0; mAfterRst = 1'b1;
    end else begin
      mAfterRst = 1'b0;
      if (clear) begin
        mAccepted = 0; mWritten = 0; mErr = 1'b0; mPend = 1'b0;
      end else begin
        if (mPend) mWritten++;
        mPend = 1'b0;
        if (reqValid && expReady) begin
          if (kind >= 8 && CHECK) begin
            mErr = 1'b1;
          end else begin
            mPend     = 1'b1;
            mPendAddr = mAccepted;
            mPendData = refEncode(kind, rs, rt, rd, shamt, funct, imm, target);
            mAccepted++;
          end
        end
      end
    end
    #1;
    chk("we", {31'b0, memWe}, {31'b0, mPend});
    chk("count", 32'(count), 32'(mWritten));
    chk("full", {31'b0, full}, {31'b0, (mAccepted == DEPTH)});
    chk("err", {31'b0, err}, {31'b0, mErr});
    if (mPend) begin
      chk("addr", 32'(memAddr), 32'(mPendAddr));
      chk("data", memData, mPendData);
    end
    if (mAfterRst) begin
      chk("rst_addr", 32'(memAddr), 32'd0);
      chk("rst_data", memData, 32'd0);
    end
    if (memWe) $display("write addr=%0d data=%08h count=%0d", memAddr, memData, count);
  endtask

  task automatic setReq(input logic [3:0] k);
    reqValid = 1'b1;
    kind     = k;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); shamt = 5'($urandom);
    funct = 6'($urandom); imm = 16'($urandom); target = 26'($urandom);
  endtask

  initial begin
    tbl[0] = '{4'd1, 5'd0,  5'd8,  5'd0,  5'd0,  6'h00, 16'h0005, 26'h0,       32'h20080005};
    tbl[1] = '{4'd0, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 26'h0,       32'h00221820};
    tbl[2] = '{4'd4, 5'd29, 5'd8,  5'd0,  5'd0,  6'h00, 16'h0004, 26'h0,       32'h8FA80004};
    tbl[3] = '{4'd6, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h10,      32'h08000010};
    tbl[4] = '{4'd7, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h10,      32'h0C000010};
    tbl[5] = '{4'd2, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 16'hFFFF, 26'h0,       32'h2822FFFF};
    tbl[6] = '{4'd3, 5'd3,  5'd4,  5'd0,  5'd0,  6'h00, 16'h0010, 26'h0,       32'h10640010};
    tbl[7] = '{4'd5, 5'd29, 5'd31, 5'd0,  5'd0,  6'h00, 16'h0008, 26'h0,       32'hAFBF0008};
    tbl[8] = '{4'd0, 5'd0,  5'd5,  5'd6,  5'd3,  6'h00, 16'hFFFF, 26'h3FFFFFF, 32'h000530C0};
    tbl[9] = '{4'd1, 5'd0,  5'd8,  5'd31, 5'd31, 6'h3F, 16'h0005, 26'h3FFFFFF, 32'h20080005};

    rst = 1'b1; clear = 1'b0; reqValid = 1'b0; kind = '0;
    rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; target = '0;
    tick(); tick();
    rst = 1'b0;

    // Known encodings streamed back-to-back from address 0.
    for (int i = 0; i < 10; i++) begin
      reqValid = 1'b1; kind = tbl[i].kind; rs = tbl[i].rs; rt = tbl[i].rt; rd = tbl[i].rd;
      shamt = tbl[i].shamt; funct = tbl[i].funct; imm = tbl[i].imm; target = tbl[i].target;
      tick();
      chk("tbl_data", memData, tbl[i].expData);
      chk("tbl_addr", 32'(memAddr), 32'(i));
    end
    reqValid = 1'b0; tick();

    // Fill to capacity with one extra request, then clear and restart.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      setReq(4'($urandom_range(0, 7)));
      tick();
    end
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_flag", {31'b0, full}, 32'd1);
    chk("full_nowrite", {31'b0, memWe}, 32'd0);
    reqValid = 1'b0; tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    setReq(4'd1); tick();
    chk("clr_addr0", 32'(memAddr), 32'd0);
    reqValid = 1'b0; tick();

    // Illegal request kind 15.
    clear = 1'b1; tick(); clear = 1'b0;
    setReq(4'hF); tick();
`ifdef ENC_CHECK_EN
    chk("ill_err", {31'b0, err}, 32'd1);
    chk("ill_nowrite", {31'b0, memWe}, 32'd0);
    reqValid = 1'b0; tick();
    chk("ill_ready", {31'b0, reqReady}, 32'd0);
    clear = 1'b1; setReq(4'd1); tick(); clear = 1'b0;
    chk("ill_clr_err", {31'b0, err}, 32'd0);
    chk("ill_clr_nowrite", {31'b0, memWe}, 32'd0);
`else
    chk("ill_we", {31'b0, memWe}, 32'd1);
    chk("ill_nop", memData, 32'd0);
`endif
    reqValid = 1'b0; tick();

    // Reset in the cycle after the third accept drops the pending write.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setReq(4'($urandom_range(0, 7))); tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_we", {31'b0, memWe}, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    setReq(4'd6); tick();
    chk("rst_next_addr", 32'(memAddr), 32'd0);
    reqValid = 1'b0; tick();

    // Random stream with occasional illegal kinds, clears and resets.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 19) == 0) setReq(4'(8 + $urandom_range(0, 7)));
      else setReq(4'($urandom_range(0, 7)));
      reqValid = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 49) == 0);
      rst      = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; clear = 1'b0; reqValid = 1'b0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
